// File: rtl/serial_rx_deframer_pkg.sv
// Shared types for the serial receive deframer: FSM state encoding and FIFO word payload.
package deser_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_DATA_DEPTH = 4;
   localparam int unsigned DEF_DIV_WIDTH  = 8;
   localparam int unsigned DEF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_RECV  = 2'd1,
      RX_DRAIN = 2'd2
   } rx_state_t;

   // Payload at default sizes; the top re-declares it at its own parameter sizes.
   typedef struct packed {
      logic [DEF_DATA_WIDTH-1:0]       data;
      logic [$clog2(DEF_DATA_DEPTH):0] idx;
   } rx_word_t;

endpackage

// File: rtl/serial_rx_deframer_if.sv
// Output word stream (valid/ready) from the deframer toward the FEC decoder.
interface serial_rx_deframer_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DATA_DEPTH = 4
);
   localparam int unsigned IW = $clog2(DATA_DEPTH) + 1;

   logic [DATA_WIDTH-1:0] word_out;
   logic [IW-1:0]         word_idx;
   logic                  word_valid;
   logic                  word_ready;

   modport master (output word_out, output word_idx, output word_valid, input word_ready);
   modport slave  (input word_out, input word_idx, input word_valid, output word_ready);

endinterface

// File: rtl/serial_rx_deframer_fifo.sv
// Synchronous word FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module rx_word_fifo
   import deser_pkg::*;
#(
   parameter type         entry_t = rx_word_t,
   parameter int unsigned DEPTH   = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  entry_t wdata,
   input  logic   pop,
   output entry_t rdata,
   output logic   full,
   output logic   empty
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_d;
   logic            do_push;
   logic            do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      count_d = count;
      case ({do_push, do_pop})
         2'b10:   count_d = count + CW'(1);
         2'b01:   count_d = count - CW'(1);
         default: count_d = count;
      endcase
   end

   // Flags are registered from the next count so they line up with the head entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem    <= '{default: '0};
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_d;
         full  <= (count_d == CW'(DEPTH));
         empty <= (count_d == '0);
      end
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/serial_rx_deframer.sv
// Serial receive deframer: mid-bit samples serial_in inside the serial_en envelope and
// reassembles LSB-first words, which leave through a small FIFO on a valid/ready stream.
module serial_rx_deframer
   import deser_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DATA_DEPTH = DEF_DATA_DEPTH,
   parameter int unsigned DIV_WIDTH  = DEF_DIV_WIDTH,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          serial_in,
   input  logic                          serial_en,
   input  logic [DIV_WIDTH-1:0]          clk_div,
   input  logic [$clog2(DATA_WIDTH):0]   width,
   input  logic [$clog2(DATA_DEPTH):0]   depth,
   serial_rx_deframer_if.master          word_bus,
   output logic                          frame_done,
   output logic                          err_short,
   output logic                          err_ovf,
   input  logic                          clear_err
);
   localparam int unsigned WW = $clog2(DATA_WIDTH) + 1;
   localparam int unsigned IW = $clog2(DATA_DEPTH) + 1;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [IW-1:0]         idx;
   } word_t;

   rx_state_t             state_q, state_d;
   logic [DIV_WIDTH-1:0]  div_q, div_d;
   logic [WW-1:0]         width_q, width_d;
   logic [IW-1:0]         depth_q, depth_d;
   logic [DIV_WIDTH-1:0]  phase_q, phase_d;
   logic [WW-1:0]         bit_q, bit_d;
   logic [IW-1:0]         word_q, word_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic                  frame_done_d;
   logic                  err_short_d;
   logic                  err_ovf_d;

   logic [DATA_WIDTH-1:0] shreg_smp;
   logic [WW-1:0]         width_clamped;
   logic [IW-1:0]         depth_clamped;
   logic                  push_c;
   logic                  pop_c;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  valid;
   word_t                 push_word;
   word_t                 head_word;

   assign width_clamped = (width > WW'(DATA_WIDTH - 1)) ? WW'(DATA_WIDTH - 1) : width;
   assign depth_clamped = (depth > IW'(DATA_DEPTH - 1)) ? IW'(DATA_DEPTH - 1) : depth;

   assign valid     = !fifo_empty;
   assign pop_c     = valid && word_bus.word_ready;
   assign push_word = '{data: shreg_smp, idx: word_q};

   // Next-state, sampler and error logic.
   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      width_d      = width_q;
      depth_d      = depth_q;
      phase_d      = phase_q;
      bit_d        = bit_q;
      word_d       = word_q;
      shreg_d      = shreg_q;
      shreg_smp    = shreg_q;
      push_c       = 1'b0;
      frame_done_d = 1'b0;
      err_short_d  = clear_err ? 1'b0 : err_short;
      err_ovf_d    = clear_err ? 1'b0 : err_ovf;

      case (state_q)
         RX_IDLE: begin
            if (serial_en) begin
               state_d = RX_RECV;
               div_d   = clk_div;
               width_d = width_clamped;
               depth_d = depth_clamped;
               phase_d = '0;
               bit_d   = '0;
               word_d  = '0;
               shreg_d = '0;
            end
         end
         RX_RECV: begin
            if (!serial_en) begin
               state_d     = RX_IDLE;
               err_short_d = 1'b1;
            end else begin
               if (phase_q == (div_q >> 1)) begin
                  shreg_smp = shreg_q | (DATA_WIDTH'(serial_in) << bit_q);
                  shreg_d   = shreg_smp;
                  if (bit_q == width_q) begin
                     push_c  = 1'b1;
                     shreg_d = '0;
                     if (word_q == depth_q) begin
                        state_d      = RX_DRAIN;
                        frame_done_d = 1'b1;
                     end
                  end
               end
               // Bit boundary: wrap phase, step bit index, roll to next word after the last bit.
               if (phase_q == div_q) begin
                  phase_d = '0;
                  if (bit_q == width_q) begin
                     bit_d  = '0;
                     word_d = word_q + IW'(1);
                  end else begin
                     bit_d = bit_q + WW'(1);
                  end
               end else begin
                  phase_d = phase_q + DIV_WIDTH'(1);
               end
            end
         end
         RX_DRAIN: begin
            if (!serial_en) begin
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase

      if (push_c && fifo_full && !pop_c) begin
         err_ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RX_IDLE;
         div_q      <= '0;
         width_q    <= '0;
         depth_q    <= '0;
         phase_q    <= '0;
         bit_q      <= '0;
         word_q     <= '0;
         shreg_q    <= '0;
         frame_done <= 1'b0;
         err_short  <= 1'b0;
         err_ovf    <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         width_q    <= width_d;
         depth_q    <= depth_d;
         phase_q    <= phase_d;
         bit_q      <= bit_d;
         word_q     <= word_d;
         shreg_q    <= shreg_d;
         frame_done <= frame_done_d;
         err_short  <= err_short_d;
         err_ovf    <= err_ovf_d;
      end
   end

   rx_word_fifo #(
      .entry_t (word_t),
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_c),
      .wdata (push_word),
      .pop   (pop_c),
      .rdata (head_word),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign word_bus.word_out   = head_word.data;
   assign word_bus.word_idx   = head_word.idx;
   assign word_bus.word_valid = valid;

endmodule

// File: tb/tb_serial_rx_deframer.sv
// Scoreboard bench for serial_rx_deframer: a serializer model drives frames and queues the
// expected words; a forked monitor pops and compares every accepted output word.
module tb_serial_rx_deframer;

   localparam int unsigned DW   = 32;
   localparam int unsigned DD   = 8;
   localparam int unsigned DIVW = 8;
   localparam int unsigned FD   = 4;
   localparam int unsigned WW   = $clog2(DW) + 1;
   localparam int unsigned IW   = $clog2(DD) + 1;

   logic            clk       = 1'b0;
   logic            rst       = 1'b1;
   logic            serial_in = 1'b0;
   logic            serial_en = 1'b0;
   logic [DIVW-1:0] clk_div   = '0;
   logic [WW-1:0]   width     = '0;
   logic [IW-1:0]   depth     = '0;
   logic            clear_err = 1'b0;
   logic            frame_done;
   logic            err_short;
   logic            err_ovf;

   serial_rx_deframer_if #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) bus ();

   serial_rx_deframer #(
      .DATA_WIDTH (DW),
      .DATA_DEPTH (DD),
      .DIV_WIDTH  (DIVW),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .serial_in  (serial_in),
      .serial_en  (serial_en),
      .clk_div    (clk_div),
      .width      (width),
      .depth      (depth),
      .word_bus   (bus),
      .frame_done (frame_done),
      .err_short  (err_short),
      .err_ovf    (err_ovf),
      .clear_err  (clear_err)
   );

   always #5 clk = ~clk;

   int          tests  = 0;
   int          fails  = 0;
   int          fd_cnt = 0;
   logic [35:0] exp_q [$];
   logic [31:0] frame_words [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Serializer model: one lead enable cycle, then LSB-first bits held clk_div+1 cycles each.
   // cut >= 0 drops serial_en after that many bits; n_exp words are queued as expected output.
   task automatic send_frame(input int w, input int d, input int div, input int cut,
                             input int n_exp, input bit clr_at_drop);
      int bits;
      bit stop;
      clk_div = DIVW'(div);
      width   = WW'(w);
      depth   = IW'(d);
      for (int k = 0; k < n_exp; k++) exp_q.push_back({frame_words[k], IW'(k)});
      serial_en = 1'b1;
      serial_in = 1'b0;
      tick();
      bits = 0;
      stop = 1'b0;
      for (int k = 0; k <= d && !stop; k++) begin
         for (int b = 0; b <= w && !stop; b++) begin
            if (bits == cut) begin
               stop = 1'b1;
            end else begin
               serial_in = (b < 32) ? frame_words[k][b] : 1'b0;
               repeat (div + 1) tick();
               bits++;
            end
         end
      end
      serial_en = 1'b0;
      serial_in = 1'b0;
      clear_err = clr_at_drop;
      tick();
      clear_err = 1'b0;
      repeat (4) tick();
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      check(name, 36'(exp_q.size()), 36'd0);
   endtask

   task automatic monitor();
      logic [35:0] got;
      logic [35:0] want;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (frame_done) fd_cnt++;
            if (bus.word_valid && bus.word_ready) begin
               got = {bus.word_out, bus.word_idx};
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_word: got %h, expected no word", got);
               end else begin
                  want = exp_q.pop_front();
                  check("word", got, want);
               end
            end
         end
      end
   endtask

   initial begin
      bus.word_ready = 1'b0;
      fork
         monitor();
      join_none

      // Reset state
      repeat (3) tick();
      check("rst_valid",      36'(bus.word_valid), 36'd0);
      check("rst_word_out",   36'(bus.word_out),   36'd0);
      check("rst_word_idx",   36'(bus.word_idx),   36'd0);
      check("rst_frame_done", 36'(frame_done),     36'd0);
      check("rst_err_short",  36'(err_short),      36'd0);
      check("rst_err_ovf",    36'(err_ovf),        36'd0);
      rst = 1'b0;
      tick();

      // Two 8-bit words at clk_div=3
      bus.word_ready = 1'b1;
      frame_words[0] = 32'h0000_00A5;
      frame_words[1] = 32'h0000_003C;
      send_frame(7, 1, 3, -1, 2, 1'b0);
      wait_drain("t1_drain");
      check("t1_frame_done", 36'(fd_cnt),    36'd1);
      check("t1_err_short",  36'(err_short), 36'd0);
      check("t1_err_ovf",    36'(err_ovf),   36'd0);

      // Full-width words, one clk per bit
      frame_words[0] = 32'hDEAD_BEEF;
      frame_words[1] = 32'h1234_5678;
      frame_words[2] = 32'h8000_0001;
      frame_words[3] = 32'hFFFF_0000;
      send_frame(31, 3, 0, -1, 4, 1'b0);
      wait_drain("t2_drain");
      check("t2_frame_done", 36'(fd_cnt),    36'd2);
      check("t2_err_short",  36'(err_short), 36'd0);
      check("t2_err_ovf",    36'(err_ovf),   36'd0);

      // Width 63 clamps to 31: word ends after 32 bits, the extra bits fall into the drain
      frame_words[0] = 32'hCAFE_F00D;
      send_frame(63, 0, 0, -1, 1, 1'b0);
      wait_drain("t2b_drain");
      check("t2b_frame_done", 36'(fd_cnt),    36'd3);
      check("t2b_err_short",  36'(err_short), 36'd0);

      // Envelope drops after 12 bits of word 1
      frame_words[0] = 32'h0000_BEEF;
      frame_words[1] = 32'h0000_1234;
      frame_words[2] = 32'h0000_5555;
      frame_words[3] = 32'h0000_AAAA;
      send_frame(15, 3, 1, 28, 1, 1'b0);
      wait_drain("t3_drain");
      check("t3_err_short",  36'(err_short),      36'd1);
      check("t3_frame_done", 36'(fd_cnt),         36'd3);
      check("t3_no_extra",   36'(bus.word_valid), 36'd0);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      check("t3_cleared", 36'(err_short), 36'd0);
      frame_words[0] = 32'h0000_005A;
      send_frame(7, 0, 2, -1, 1, 1'b0);
      wait_drain("t3_next_frame");
      check("t3_next_done", 36'(fd_cnt), 36'd4);

      // Six words into a 4-entry FIFO with the consumer stalled
      bus.word_ready = 1'b0;
      frame_words[0] = 32'h11;
      frame_words[1] = 32'h22;
      frame_words[2] = 32'h33;
      frame_words[3] = 32'h44;
      frame_words[4] = 32'h55;
      frame_words[5] = 32'h66;
      send_frame(7, 5, 1, -1, 4, 1'b0);
      check("t4_err_ovf",    36'(err_ovf),        36'd1);
      check("t4_err_short",  36'(err_short),      36'd0);
      check("t4_valid_held", 36'(bus.word_valid), 36'd1);
      check("t4_head_data",  36'(bus.word_out),   36'h11);
      check("t4_head_idx",   36'(bus.word_idx),   36'd0);
      check("t4_frame_done", 36'(fd_cnt),         36'd5);
      bus.word_ready = 1'b1;
      wait_drain("t4_drain");
      repeat (2) tick();
      check("t4_dropped", 36'(bus.word_valid), 36'd0);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      check("t4_ovf_cleared", 36'(err_ovf), 36'd0);

      // Reset mid-frame with a word already sitting in the FIFO
      bus.word_ready = 1'b0;
      clk_div   = DIVW'(1);
      width     = WW'(7);
      depth     = IW'(1);
      serial_en = 1'b1;
      serial_in = 1'b0;
      tick();
      for (int b = 0; b < 8; b++) begin
         serial_in = b[0] | b[1];
         repeat (2) tick();
      end
      serial_in = 1'b1;
      repeat (3) tick();
      check("t5_pre_rst_valid", 36'(bus.word_valid), 36'd1);
      rst = 1'b1;
      tick();
      check("t5_rst_valid", 36'(bus.word_valid), 36'd0);
      serial_en = 1'b0;
      serial_in = 1'b0;
      rst       = 1'b0;
      tick();
      bus.word_ready = 1'b1;
      frame_words[0] = 32'h0000_00FF;
      send_frame(7, 0, 0, -1, 1, 1'b0);
      wait_drain("t5_drain");
      repeat (2) tick();
      check("t5_no_extra",   36'(bus.word_valid), 36'd0);
      check("t5_err_short",  36'(err_short),      36'd0);
      check("t5_err_ovf",    36'(err_ovf),        36'd0);
      check("t5_frame_done", 36'(fd_cnt),         36'd6);

      // New error in the same cycle as clear_err: the set wins
      frame_words[0] = 32'h0F;
      frame_words[1] = 32'hF0;
      send_frame(7, 1, 1, 4, 0, 1'b1);
      check("t5_set_over_clear", 36'(err_short), 36'd1);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      check("t5_clear_after", 36'(err_short), 36'd0);

      check("final_queue_empty", 36'(exp_q.size()), 36'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
